// File: rtl/or_gate_unit.sv
// or_gate_unit: registered OR / NOR / sticky-OR / OR-reduce stage with a one-cycle valid strobe
module or_gate_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             any
);
    localparam logic [1:0] MODE_OR    = 2'b00;
    localparam logic [1:0] MODE_NOR   = 2'b01;
    localparam logic [1:0] MODE_ACCUM = 2'b10;

    logic [WIDTH-1:0] y_q, y_d, r;
    logic             y_valid_q, y_valid_d, any_q, any_d;

    always_comb begin
        r = mode == MODE_OR    ? a | b :
            mode == MODE_NOR   ? ~(a | b) :
            mode == MODE_ACCUM ? y_q | a | b :
                                 WIDTH'(|(a | b));
        y_d       = clear ? '0   : in_valid ? r    : y_q;
        any_d     = clear ? 1'b0 : in_valid ? |r   : any_q;
        y_valid_d = in_valid && !clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            any_q     <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            any_q     <= any_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign any     = any_q;
endmodule

// File: tb/tb_or_gate_unit.sv
// tb_or_gate_unit: directed spec cases plus randomized ops against a behavioural model
module tb_or_gate_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0, c1 = 1'b0;
    logic [1:0] m1 = 2'b00;
    logic       y1, yv1, any1;
    logic [7:0] a8 = '0, b8 = '0, y8;
    logic [1:0] m8 = 2'b00;
    logic       v8 = 1'b0, c8 = 1'b0, yv8, any8;
    logic [7:0] m_y = '0;
    logic       m_v = 1'b0, m_any = 1'b0;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    or_gate_unit #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .mode(m1),
        .clear(c1), .y(y1), .y_valid(yv1), .any(any1)
    );

    or_gate_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8), .mode(m8),
        .clear(c8), .y(y8), .y_valid(yv8), .any(any8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                              input logic tv, input logic tc);
        logic [7:0] r;
        if (tc) begin
            m_y = '0; m_any = 1'b0; m_v = 1'b0;
        end else if (tv) begin
            case (tm)
                2'd0: r = ta | tb;
                2'd1: r = ~(ta | tb);
                2'd2: r = m_y | ta | tb;
                default: r = ((ta | tb) != 0) ? 8'd1 : 8'd0;
            endcase
            m_y = r; m_any = (r != 0); m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                       input logic tv, input logic tc, input string tag);
        a8 = ta; b8 = tb; m8 = tm; v8 = tv; c8 = tc;
        @(posedge clk);
        model_step(ta, tb, tm, tv, tc);
        #1;
        check({tag, ".y"}, y8, m_y);
        check({tag, ".y_valid"}, yv8, m_v);
        check({tag, ".any"}, any8, m_any);
    endtask

    initial begin
        #12;
        check("rst.y1", y1, 0); check("rst.yv1", yv1, 0); check("rst.any1", any1, 0);
        check("rst.y8", y8, 0); check("rst.yv8", yv8, 0); check("rst.any8", any8, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = i[1]; b1 = i[0]; v1 = 1'b1; m1 = 2'b00;
            @(posedge clk);
            #1;
            check("tt.y", y1, (i != 0));
            check("tt.y_valid", yv1, 1);
        end
        v1 = 1'b0;
        op8(8'h0F, 8'h30, 2'd1, 1, 0, "nor1");
        check("nor1.c", {any8, y8}, {1'b1, 8'hC0});
        op8(8'hFF, 8'hFF, 2'd1, 1, 0, "nor2");
        check("nor2.c", {any8, y8}, {1'b0, 8'h00});
        op8(8'h00, 8'h00, 2'd2, 0, 1, "clr");
        op8(8'h01, 8'h00, 2'd2, 1, 0, "acc1");
        check("acc1.c", y8, 8'h01);
        op8(8'h00, 8'h10, 2'd2, 1, 0, "acc2");
        check("acc2.c", y8, 8'h11);
        op8(8'h80, 8'h00, 2'd2, 1, 0, "acc3");
        check("acc3.c", y8, 8'h91);
        op8(8'h00, 8'h00, 2'd2, 0, 0, "hold1");
        op8(8'h00, 8'h00, 2'd2, 0, 0, "hold2");
        check("hold.c", {yv8, y8}, {1'b0, 8'h91});
        #2 rst_n = 1'b0;
        #1;
        check("arst.y", y8, 0); check("arst.yv", yv8, 0); check("arst.any", any8, 0);
        m_y = '0; m_v = 1'b0; m_any = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        op8(8'h02, 8'h00, 2'd2, 1, 0, "acc_post_rst");
        check("acc_post_rst.c", y8, 8'h02);
        op8(8'h00, 8'h40, 2'd3, 1, 0, "red1");
        check("red1.c", y8, 8'h01);
        op8(8'h00, 8'h00, 2'd3, 1, 0, "red2");
        check("red2.c", {any8, y8}, {1'b0, 8'h00});
        op8(8'h91, 8'h00, 2'd0, 1, 0, "pre_prio");
        op8(8'hFF, 8'h00, 2'd0, 1, 1, "prio");
        check("prio.c", {yv8, y8}, {1'b0, 8'h00});
        for (int i = 0; i < 300; i++)
            op8(8'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), "rnd");
        v8 = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/or_gate_unit.md
# or_gate_unit

Registered, parameterizable bitwise OR datapath stage. It combines two equal-width operands by OR, NOR, sticky-OR accumulation or OR-reduction, and presents the result one clock later with a valid flag. It is a single-clock pipeline element that sits between a producer with a valid strobe and downstream logic that samples `y` on `y_valid`. The RTL module name is `or_gate_unit`.

## Interface
Parameters:
- `WIDTH`, default 1: operand and result width in bits. Legal range is 1 to 64.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset. One clock; reset is asynchronous and active-low.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `in_valid`  input  1  operands and `mode` are sampled when high.
- `mode`  input  2  operation select: 00 OR, 01 NOR, 10 ACCUM, 11 REDUCE.
- `clear`  input  1  synchronous clear of the result and accumulator.
- `y`  output  WIDTH  registered result.
- `y_valid`  output  1  high for one cycle per accepted operation.
- `any`  output  1  registered OR-reduction of `y` (high when any result bit is 1).

## Operation
- On a rising edge with `in_valid`=1 and `clear`=0, the block computes `r` from the sampled operands and writes `y`<=`r`:
  - OR: `r` = `a` | `b`.
  - NOR: `r` = ~(`a` | `b`).
  - ACCUM: `r` = `y` | `a` | `b`. The sticky accumulator is `y` itself.
  - REDUCE: `r[0]` = |(`a` | `b`), with all other bits 0.
- On accepted cycles, `any` is set to |`r` at the same edge as `y`.
- When `in_valid`=0 and `clear`=0: `y` and `any` hold their values, and `y_valid` is 0.
- `clear`=1 has priority over `in_valid`. At that edge `y`<=0, `any`<=0 and `y_valid`<=0, and the operands are discarded.
- `mode` is sampled only with `in_valid`. A mode change takes effect on the next accepted operation. Switching into ACCUM accumulates onto whatever `y` currently holds.
- There is no back-pressure. Every cycle with `in_valid`=1 is accepted, so the block supports full throughput with back-to-back operations.
- X or Z on `a`/`b` is not masked. It propagates per standard Verilog operator semantics.

## Timing
- Latency is 1 cycle: operands accepted at edge N appear on `y`/`any` after edge N, with `y_valid`=1 for exactly the cycle following edge N.
- Reset values while `rst_n`=0 are `y`=0, `y_valid`=0 and `any`=0, asynchronous to `clk`.
- Asserting `rst_n` low mid-operation discards any in-flight result immediately. The first accepted operation after release behaves as if from power-up, so ACCUM starts from 0.
- Reset release is synchronised by the integrator. The block samples inputs from the first rising edge after `rst_n` rises.
- There are no combinational paths from inputs to outputs.

## Test plan
- Truth table with WIDTH=1 and `mode`=OR: apply `a`,`b` = 00, 01, 10, 11 with `in_valid`=1 on consecutive cycles. `y` must be 0, 1, 1, 1 one cycle later each time, and `y_valid` must stay high for 4 cycles.
- NOR with WIDTH=8: `a`=0x0F, `b`=0x30. The next cycle must give `y`=0xC0 and `any`=1. Then `a`=`b`=0xFF must give `y`=0x00 and `any`=0.
- ACCUM with WIDTH=8: apply `clear`, then accept 0x01|0x00, 0x00|0x10 and 0x80|0x00. `y` must go 0x01, 0x11, 0x91. Next, drop `in_valid` for 2 cycles: `y` must hold 0x91 and `y_valid` must be 0.
- REDUCE with WIDTH=8: `a`=0x00, `b`=0x40 must give `y`=0x01. `a`=`b`=0x00 must give `y`=0x00 and `any`=0.
- Priority and reset:
  - `clear`=1 together with `in_valid`=1, `a`=0xFF: the next cycle must give `y`=0, `y_valid`=0.
  - Drive `rst_n` low between clock edges while `y`=0x91: `y`, `any` and `y_valid` must go to 0 immediately, without waiting for a clock edge.
